// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared constants and types for the processor DIN-path feeder
// Purpose: word width, feeder FSM state encoding and a run-length clamp helper,
//          imported by the feeder interface, memory and top.
// Ports:   none (package).
package proc_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FETCH   = 2'd1,
    ST_PRESENT = 2'd2,
    ST_DONE    = 2'd3
  } feeder_state_e;

  // Requested run lengths beyond the memory depth feed the whole image once.
  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned depth);
    return (len > depth) ? depth : len;
  endfunction

endpackage

// File: rtl/prog_feeder_if.sv
// rtl/prog_feeder_if.sv - load, control, status and word handshake bundle of the feeder
// Purpose: groups every non-clock signal of prog_feeder.
// Ports (master = feeder side):
//   in : wr_en, wr_addr, wr_data  program memory load port
//   in : start, len, stop         run control (len is AW+1 bits, 0..DEPTH)
//   out: data_out, data_valid     word presented to the processor
//   in : data_ack                 consumer took data_out
//   out: pc, busy, done, wr_err   status
interface prog_feeder_if #(
  parameter int WORD_W = proc_pkg::WORD_W,
  parameter int AW     = 5
);

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [WORD_W-1:0] wr_data;
  logic              start;
  logic [AW:0]       len;
  logic              stop;
  logic [WORD_W-1:0] data_out;
  logic              data_valid;
  logic              data_ack;
  logic [AW-1:0]     pc;
  logic              busy;
  logic              done;
  logic              wr_err;

  modport master (
    input  wr_en, wr_addr, wr_data, start, len, stop, data_ack,
    output data_out, data_valid, pc, busy, done, wr_err
  );

  modport slave (
    output wr_en, wr_addr, wr_data, start, len, stop, data_ack,
    input  data_out, data_valid, pc, busy, done, wr_err
  );

endinterface

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - DEPTH x WORD_W program memory, one write port, one sync read port
// Purpose: holds the program/data image; read data is registered and write-first
//          when the write and read address collide in the same cycle.
// Ports:
//   clock, reset    clock, async active-high reset (clears only the read register)
//   we, waddr, wdata  write port
//   re, raddr         read request; rdata updates on the next edge, else holds
//   rdata             registered read data
module prog_mem #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q, rdata_d;

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // rdata holds between reads so the presented word survives after valid drops.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/prog_feeder.sv
// rtl/prog_feeder.sv - program/data word feeder driving the processor DIN handshake
// Purpose: loads an image while idle, then presents words 0..len-1 one at a time,
//          each held until data_ack. Optional macro FEEDER_LOOP_EN: the run wraps to
//          word 0 after the last word and ends only on stop or reset.
// Ports:
//   clock   system clock, all state on rising edge
//   reset   asynchronous active-high reset
//   bus     prog_feeder_if.master: load port, start/len/stop, data_out/data_valid/
//           data_ack handshake, pc/busy/done/wr_err status
module prog_feeder #(
  parameter int WORD_W = proc_pkg::WORD_W,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  prog_feeder_if.master bus
);

  import proc_pkg::*;

  localparam int LW = AW + 1;

  feeder_state_e     state_q, state_d;
  logic [AW-1:0]     pc_q, pc_d;
  logic [LW-1:0]     len_q, len_d;
  logic              wr_err_q, wr_err_d;
  logic [LW-1:0]     len_req;
  logic              idle_like;
  logic              last_word;
  logic              rd_en;
  logic              mem_we;
  logic [WORD_W-1:0] rd_data;

  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign len_req   = LW'(clamp_len(32'(bus.len), DEPTH));
  assign last_word = ({1'b0, pc_q} == (len_q - LW'(1)));
  // Loads are only safe while no fetch can race them.
  assign mem_we    = bus.wr_en && idle_like;

  prog_mem #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clock (clock),
    .reset (reset),
    .we    (mem_we),
    .waddr (bus.wr_addr),
    .wdata (bus.wr_data),
    .re    (rd_en),
    .raddr (pc_q),
    .rdata (rd_data)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    len_d    = len_q;
    rd_en    = 1'b0;
    wr_err_d = bus.wr_en && !idle_like;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          if (len_req == '0) begin
            state_d = ST_DONE;
          end else begin
            pc_d    = '0;
            len_d   = len_req;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (bus.data_ack) begin
          if (last_word) begin
`ifdef FEEDER_LOOP_EN
            pc_d    = '0;
            state_d = ST_FETCH;
`else
            state_d = ST_DONE;
`endif
          end else begin
            pc_d    = pc_q + AW'(1);
            state_d = ST_FETCH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // stop overrides everything; the pending read is suppressed so data_out keeps the last word.
    if (bus.stop) begin
      state_d = ST_IDLE;
      pc_d    = pc_q;
      len_d   = len_q;
      rd_en   = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      len_q    <= '0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      len_q    <= len_d;
      wr_err_q <= wr_err_d;
    end
  end

  assign bus.data_out   = rd_data;
  assign bus.data_valid = (state_q == ST_PRESENT);
  assign bus.pc         = pc_q;
  assign bus.busy       = (state_q == ST_FETCH) || (state_q == ST_PRESENT);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.wr_err     = wr_err_q;

endmodule
